// File: rtl/axis_frame_arbiter.sv
// Two-source AXI-Stream frame arbiter: whole-frame round-robin grants, max-length
// truncation (remaining beats are dropped) and a programmable inter-frame gap.
module axis_frame_arbiter #(
    parameter int Data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [Data_width-1:0] s0_data,
    input  logic                  s0_valid,
    input  logic                  s0_last,
    output logic                  s0_ready,
    input  logic [Data_width-1:0] s1_data,
    input  logic                  s1_valid,
    input  logic                  s1_last,
    output logic                  s1_ready,
    input  logic [Data_width-1:0] k,
    input  logic [Data_width-1:0] len,
    output logic [Data_width-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  trunc_err
);

    typedef enum logic [1:0] {IDLE, XFER, DROP, GAP} state_t;

    state_t                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  last_srv_q, last_srv_d;
    logic [Data_width-1:0] cnt_q, cnt_d;
    logic [Data_width-1:0] gap_q, gap_d;
    logic [Data_width-1:0] len_q, len_d;
    logic [Data_width-1:0] k_q, k_d;

    logic                  sel;
    logic [Data_width-1:0] g_data;
    logic                  g_valid;
    logic                  g_last;
    logic                  g_ready;
    logic                  limit;
    logic                  win1;
    logic                  frame_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            last_srv_q <= 1'b1;
            cnt_q      <= '0;
            gap_q      <= '0;
            len_q      <= '0;
            k_q        <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_srv_q <= last_srv_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            len_q      <= len_d;
            k_q        <= k_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_srv_d = last_srv_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        len_d      = len_q;
        k_d        = k_q;
        m_data     = '0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        trunc_err  = 1'b0;
        g_ready    = 1'b0;
        win1       = 1'b0;
        frame_end  = 1'b0;

        sel     = grant_q[1];
        g_data  = sel ? s1_data  : s0_data;
        g_valid = sel ? s1_valid : s0_valid;
        g_last  = sel ? s1_last  : s0_last;
        limit   = (len_q != '0) && (cnt_q == len_q - Data_width'(1));

        case (state_q)
            IDLE: begin
                if (s0_valid || s1_valid) begin
                    // On contention prefer whichever source was not served last.
                    win1    = (s0_valid && s1_valid) ? !last_srv_q : s1_valid;
                    grant_d = win1 ? 2'b10 : 2'b01;
                    len_d   = len;
                    k_d     = k;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                m_data  = g_data;
                m_valid = g_valid;
                m_last  = g_last | limit;
                g_ready = m_ready;
                if (g_valid && m_ready) begin
                    cnt_d = cnt_q + Data_width'(1);
                    if (g_last) begin
                        frame_end = 1'b1;
                    end else if (limit) begin
                        trunc_err = 1'b1;
                        state_d   = DROP;
                    end
                end
            end
            DROP: begin
                g_ready = 1'b1;
                if (g_valid && g_last) frame_end = 1'b1;
            end
            GAP: begin
                if (gap_q == k_q - Data_width'(1)) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end else begin
                    gap_d = gap_q + Data_width'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase

        // Frame fully consumed (delivered or drained): record owner, enter the gap.
        if (frame_end) begin
            last_srv_d = sel;
            gap_d      = '0;
            if (k_q == '0) begin
                state_d = IDLE;
                grant_d = 2'b00;
            end else begin
                state_d = GAP;
            end
        end
    end

    assign s0_ready = g_ready & ~sel;
    assign s1_ready = g_ready &  sel;
    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter: inputs change 1 time unit after each
// rising edge, outputs are checked 1 unit later.
module tb_axis_frame_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] s0_data = '0, s1_data = '0;
    logic       s0_valid = 1'b0, s0_last = 1'b0;
    logic       s1_valid = 1'b0, s1_last = 1'b0;
    logic       s0_ready, s1_ready;
    logic [7:0] k = '0, len = '0;
    logic [7:0] m_data;
    logic       m_valid, m_last;
    logic       m_ready = 1'b1;
    logic [1:0] grant;
    logic       busy, trunc_err;

    int checks   = 0;
    int failures = 0;

    axis_frame_arbiter #(.Data_width(8)) dut (
        .clk(clk), .rst(rst),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
        .k(k), .len(len),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .grant(grant), .busy(busy), .trunc_err(trunc_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [7:0] b0, b1, beat;
        int         g;

        // Reset state
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mlast", m_last, 0);
        chk("rst_mdata", m_data, 0);
        chk("rst_s0rdy", s0_ready, 0);
        chk("rst_s1rdy", s1_ready, 0);
        chk("rst_trunc", trunc_err, 0);
        @(negedge clk);
        rst = 1'b1;

        // 1: single 8-beat frame, len=8, k=1
        tick();
        len = 8; k = 1;
        s0_valid = 1; s0_data = 1; s0_last = 0;
        #1;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_s0rdy", s0_ready, 0);
        chk("t1_idle_mvalid", m_valid, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            s0_data = 8'(i); s0_last = (i == 8);
            #1;
            chk("t1_grant", grant, 2'b01);
            chk("t1_mvalid", m_valid, 1);
            chk("t1_mdata", m_data, i);
            chk("t1_mlast", m_last, (i == 8));
            chk("t1_s0rdy", s0_ready, 1);
            chk("t1_trunc", trunc_err, 0);
        end
        tick();
        s0_data = 8'h11; s0_last = 1;
        #1;
        chk("t1_gap_busy", busy, 1);
        chk("t1_gap_mvalid", m_valid, 0);
        chk("t1_gap_s0rdy", s0_ready, 0);
        chk("t1_gap_grant", grant, 2'b01);
        tick();
        #1;
        chk("t1_idle2_busy", busy, 0);
        chk("t1_idle2_grant", grant, 0);
        tick();
        #1;
        chk("t1_next_grant", grant, 2'b01);
        chk("t1_next_mdata", m_data, 8'h11);
        chk("t1_next_mlast", m_last, 1);
        tick();
        s0_valid = 0; s0_last = 0;
        #1;
        chk("t1_gap2_busy", busy, 1);

        // 2: both sources offer 4-beat frames; s0 was served last so s1 goes first
        for (int f = 0; f < 4; f++) begin
            g = (f % 2 == 0) ? 1 : 0;
            tick();
            s0_valid = 1; s0_data = 8'h20; s0_last = 0;
            s1_valid = 1; s1_data = 8'h40; s1_last = 0;
            #1;
            chk("t2_idle_grant", grant, 0);
            chk("t2_idle_busy", busy, 0);
            chk("t2_idle_mvalid", m_valid, 0);
            for (int b = 0; b < 4; b++) begin
                tick();
                s0_data = 8'h20 + ((g == 0) ? 8'(b) : 8'd0);
                s0_last = (g == 0) && (b == 3);
                s1_data = 8'h40 + ((g == 1) ? 8'(b) : 8'd0);
                s1_last = (g == 1) && (b == 3);
                #1;
                chk("t2_grant", grant, (g == 1) ? 2'b10 : 2'b01);
                chk("t2_mdata", m_data, ((g == 1) ? 8'h40 : 8'h20) + b);
                chk("t2_mlast", m_last, (b == 3));
                chk("t2_other_rdy", (g == 1) ? s0_ready : s1_ready, 0);
            end
            tick();
            if (f == 3) begin
                s0_valid = 0; s1_valid = 0;
            end
            s0_last = 0; s1_last = 0;
            #1;
            chk("t2_gap_busy", busy, 1);
            chk("t2_gap_mvalid", m_valid, 0);
        end

        // 3: len=4 truncates a 6-beat frame
        tick();
        len = 4;
        s0_valid = 1; s0_data = 1; s0_last = 0;
        #1;
        chk("t3_idle_busy", busy, 0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            s0_data = 8'(i); s0_last = (i == 6);
            #1;
            chk("t3_s0rdy", s0_ready, 1);
            chk("t3_mvalid", m_valid, (i <= 4));
            chk("t3_trunc", trunc_err, (i == 4));
            if (i <= 4) begin
                chk("t3_mdata", m_data, i);
                chk("t3_mlast", m_last, (i == 4));
            end
        end
        tick();
        s0_valid = 0; s0_last = 0;
        s1_valid = 1; s1_data = 8'h55; s1_last = 1;
        #1;
        chk("t3_gap_busy", busy, 1);
        chk("t3_gap_trunc", trunc_err, 0);
        tick();
        #1;
        chk("t3_idle_grant", grant, 0);
        tick();
        #1;
        chk("t3_next_grant", grant, 2'b10);
        chk("t3_next_mdata", m_data, 8'h55);
        chk("t3_next_mlast", m_last, 1);
        chk("t3_next_s1rdy", s1_ready, 1);

        // 4: 3-cycle backpressure on beat 3 of an 8-beat frame
        tick();
        s1_valid = 0; s1_last = 0;
        len = 8;
        tick();
        s0_valid = 1; s0_data = 1; s0_last = 0;
        #1;
        chk("t4_idle_busy", busy, 0);
        beat = 1;
        for (int c = 0; c < 11; c++) begin
            tick();
            m_ready = !(c >= 2 && c < 5);
            s0_data = beat; s0_last = (beat == 8);
            #1;
            chk("t4_grant", grant, 2'b01);
            chk("t4_mvalid", m_valid, 1);
            chk("t4_mdata", m_data, beat);
            chk("t4_mlast", m_last, (beat == 8));
            chk("t4_s0rdy", s0_ready, m_ready);
            if (m_ready) beat++;
        end
        tick();
        s0_valid = 0; s0_last = 0; m_ready = 1;
        #1;
        chk("t4_gap_busy", busy, 1);
        chk("t4_gap_mvalid", m_valid, 0);

        // 5: asynchronous reset during beat 3 of an s1 frame
        tick();
        s1_valid = 1; s1_data = 8'h61; s1_last = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            s1_data = 8'h60 + 8'(i);
            #1;
            chk("t5_grant", grant, 2'b10);
            chk("t5_mdata", m_data, 8'h60 + i);
        end
        chk("t5_s1rdy_pre", s1_ready, 1);
        rst = 0;
        s0_valid = 1; s0_data = 8'h71; s0_last = 1;
        #1;
        chk("t5_rst_grant", grant, 0);
        chk("t5_rst_mvalid", m_valid, 0);
        chk("t5_rst_s1rdy", s1_ready, 0);
        chk("t5_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1;
        tick();
        #1;
        chk("t5_post_grant", grant, 2'b01);
        chk("t5_post_mdata", m_data, 8'h71);
        tick();
        s0_valid = 0; s0_last = 0; s1_valid = 0;
        #1;
        chk("t5_gap_busy", busy, 1);

        // 6: k=0, len=0, back-to-back 20-beat frames
        tick();
        k = 0; len = 0;
        s0_valid = 1; s0_data = 1; s0_last = 0;
        #1;
        chk("t6_idle_busy", busy, 0);
        for (int f = 0; f < 2; f++) begin
            for (int i = 1; i <= 20; i++) begin
                tick();
                s0_data = 8'(i); s0_last = (i == 20);
                #1;
                chk("t6_mvalid", m_valid, 1);
                chk("t6_mdata", m_data, i);
                chk("t6_mlast", m_last, (i == 20));
                chk("t6_trunc", trunc_err, 0);
            end
            tick();
            s0_data = 1; s0_last = 0;
            if (f == 1) s0_valid = 0;
            #1;
            chk("t6_dead_busy", busy, 0);
            chk("t6_dead_grant", grant, 0);
            chk("t6_dead_mvalid", m_valid, 0);
        end
        tick();
        #1;
        chk("t6_end_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
